// File: rtl/cpu_trace_uart.sv
// Debug-bus trace UART: shadows the CPU regfile scan, snapshots PC/pipeline/regs on each
// PC change or TRIG, and streams the snapshot as 8N1 bytes. Optional: CPU_TRACE_MEMUPD_EN.
module cpu_trace_uart #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SCAN_VALID,
   input  logic [3:0]  cpuout_regfile_ra,
   input  logic [15:0] cpuout_regfile_rd,
   input  logic [7:0]  cpuout_PC,
   input  logic [15:0] cpuout_IF_insn,
   input  logic [15:0] cpuout_ID_insn,
   input  logic [15:0] cpuout_EX_insn,
   input  logic [15:0] cpuout_MEM_insn,
   input  logic [15:0] cpuout_WB_insn,
   input  logic        cpuout_memupdate,
   input  logic [7:0]  cpuout_memaddr,
   input  logic [15:0] cpuout_memdata,
   input  logic        TRIG,
   output logic        TX,
   output logic        BUSY,
   output logic        OVERRUN
);

`ifdef CPU_TRACE_MEMUPD_EN
   localparam int NB = 48;
`else
   localparam int NB = 44;
`endif
   localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [5:0]  LAST_BYTE   = 6'(NB - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

   state_t                 r_state, w_next;
   logic [0:15][15:0]      r_shadow;
   logic [0:15][15:0]      w_shadow_wf;
   logic [7:0]             r_last_pc;
   logic                   r_pending;
   logic                   r_overrun;
   logic [0:NB-1][7:0]     r_frame;
   logic [0:NB-1][7:0]     w_snap;
   logic [5:0]             r_byte;
   logic [2:0]             r_bit;
   logic [15:0]            r_baud;
   logic                   w_trig;
   logic                   w_busy;
   logic                   w_baud_done;
   logic [7:0]             w_cur_byte;
   logic [31:0]            w_tail;

   assign w_trig      = (cpuout_PC != r_last_pc) | TRIG;
   assign w_busy      = (r_state != S_IDLE);
   assign w_baud_done = (r_baud == 16'd0);
   assign w_cur_byte  = r_frame[r_byte];
   assign BUSY        = w_busy;
   assign OVERRUN     = r_overrun;

   // Snapshot sees a scan write landing in the LOAD cycle (write-first).
   for (genvar g = 0; g < 16; g++) begin : g_wf
      assign w_shadow_wf[g] = (SCAN_VALID && (cpuout_regfile_ra == 4'(g))) ?
                              cpuout_regfile_rd : r_shadow[g];
   end

`ifdef CPU_TRACE_MEMUPD_EN
   logic        r_mem_flag;
   logic [7:0]  r_mem_addr;
   logic [15:0] r_mem_data;

   // Record is handed to the frame at LOAD; a write in that same cycle seeds the next frame.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_mem_flag <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else if (cpuout_memupdate) begin
         r_mem_flag <= 1'b1;
         r_mem_addr <= cpuout_memaddr;
         r_mem_data <= cpuout_memdata;
      end else if (r_state == S_LOAD) begin
         r_mem_flag <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end
   end

   assign w_tail = {7'd0, r_mem_flag, r_mem_addr, r_mem_data};
   assign w_snap = {8'hA5, cpuout_PC, cpuout_IF_insn, cpuout_ID_insn, cpuout_EX_insn,
                    cpuout_MEM_insn, cpuout_WB_insn, w_shadow_wf, w_tail};
`else
   logic w_unused_mem;
   assign w_tail       = '0;
   assign w_unused_mem = ^{cpuout_memupdate, cpuout_memaddr, cpuout_memdata, w_tail};
   assign w_snap = {8'hA5, cpuout_PC, cpuout_IF_insn, cpuout_ID_insn, cpuout_EX_insn,
                    cpuout_MEM_insn, cpuout_WB_insn, w_shadow_wf};
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_pending) w_next = S_LOAD;
         S_LOAD:  w_next = S_START;
         S_START: if (w_baud_done) w_next = S_DATA;
         S_DATA:  if (w_baud_done && (r_bit == 3'd7)) w_next = S_STOP;
         S_STOP:  if (w_baud_done) w_next = (r_byte == LAST_BYTE) ? S_IDLE : S_START;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      TX = 1'b1;
      case (r_state)
         S_START: TX = 1'b0;
         S_DATA:  TX = w_cur_byte[r_bit];
         default: TX = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (r_state == S_LOAD) r_frame <= w_snap;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_shadow  <= '0;
         r_last_pc <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
         r_byte    <= '0;
         r_bit     <= '0;
         r_baud    <= '0;
      end else begin
         r_last_pc <= cpuout_PC;
         if (SCAN_VALID) r_shadow[cpuout_regfile_ra] <= cpuout_regfile_rd;
         // A trigger during LOAD starts a fresh pending frame rather than coalescing.
         r_overrun <= w_trig & w_busy & r_pending & (r_state != S_LOAD);
         if (w_trig)                  r_pending <= 1'b1;
         else if (r_state == S_LOAD)  r_pending <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_byte <= '0;
               r_bit  <= '0;
               r_baud <= BAUD_RELOAD;
            end
            S_START: begin
               if (w_baud_done) begin
                  r_baud <= BAUD_RELOAD;
                  r_bit  <= '0;
               end else r_baud <= r_baud - 16'd1;
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud <= BAUD_RELOAD;
                  r_bit  <= r_bit + 3'd1;
               end else r_baud <= r_baud - 16'd1;
            end
            S_STOP: begin
               if (w_baud_done) begin
                  r_baud <= BAUD_RELOAD;
                  if (r_byte != LAST_BYTE) r_byte <= r_byte + 6'd1;
               end else r_baud <= r_baud - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_trace_uart.sv
// Bench for cpu_trace_uart: UART receiver plus queue-based frame model, table vectors,
// hand-written corner sequences and randomized frames.
module tb_cpu_trace_uart;
   localparam int CPB = 4;
`ifdef CPU_TRACE_MEMUPD_EN
   localparam int NB = 48;
`else
   localparam int NB = 44;
`endif

   logic        CLK = 1'b0;
   logic        RST_N, SCAN_VALID, memupd, trig;
   logic [3:0]  ra;
   logic [15:0] rd, if_i, id_i, ex_i, mem_i, wb_i, memdata;
   logic [7:0]  pc, memaddr;
   logic        TX, BUSY, OVERRUN;

   cpu_trace_uart #(.CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK), .RST_N(RST_N), .SCAN_VALID(SCAN_VALID),
      .cpuout_regfile_ra(ra), .cpuout_regfile_rd(rd), .cpuout_PC(pc),
      .cpuout_IF_insn(if_i), .cpuout_ID_insn(id_i), .cpuout_EX_insn(ex_i),
      .cpuout_MEM_insn(mem_i), .cpuout_WB_insn(wb_i),
      .cpuout_memupdate(memupd), .cpuout_memaddr(memaddr), .cpuout_memdata(memdata),
      .TRIG(trig), .TX(TX), .BUSY(BUSY), .OVERRUN(OVERRUN));

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int nchk = 0, nerr = 0;
   logic [15:0] m_sh [16];
   logic        m_mflag;
   logic [7:0]  m_maddr;
   logic [15:0] m_mdata;
   logic [7:0]  exp_q[$], got_q[$], rx_q[$];

   // 8N1 receiver sampling mid-bit on the falling clock edge.
   int   rx_t = 0, rx_ferr = 0, frame_fall = -1, ovr_cnt = 0, ovr_cyc = -1;
   logic rx_act = 1'b0;
   logic [7:0] rx_sh = '0;
   always @(negedge CLK) begin
      if (OVERRUN === 1'b1) begin ovr_cnt++; ovr_cyc = cyc; end
      if (RST_N !== 1'b1) rx_act = 1'b0;
      else if (!rx_act) begin
         if (TX === 1'b0) begin
            rx_act = 1'b1; rx_t = 0;
            if (rx_q.size() == 0) frame_fall = cyc;
         end
      end else begin
         rx_t++;
         if (rx_t == 2 && TX !== 1'b0) rx_ferr++;
         else if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 2) % 4) == 0) rx_sh = {TX, rx_sh[7:1]};
         else if (rx_t == 38) begin
            if (TX !== 1'b1) rx_ferr++;
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
         end
      end
   end

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endfunction

   function automatic void build_exp();
      logic [15:0] ins [5];
      ins = '{if_i, id_i, ex_i, mem_i, wb_i};
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(pc);
      foreach (ins[i]) begin exp_q.push_back(ins[i][15:8]); exp_q.push_back(ins[i][7:0]); end
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(m_sh[i][15:8]); exp_q.push_back(m_sh[i][7:0]);
      end
`ifdef CPU_TRACE_MEMUPD_EN
      exp_q.push_back({7'd0, m_mflag}); exp_q.push_back(m_maddr);
      exp_q.push_back(m_mdata[15:8]);   exp_q.push_back(m_mdata[7:0]);
      m_mflag = 1'b0; m_maddr = '0; m_mdata = '0;
`endif
   endfunction

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic scan_write(input logic sv, input logic [3:0] a, input logic [15:0] d);
      SCAN_VALID = sv; ra = a; rd = d;
      if (sv) m_sh[a] = d;
      tick();
      SCAN_VALID = 1'b0; ra = 4'($urandom); rd = 16'($urandom);
   endtask

   task automatic pulse_trig(output int c0);
      c0 = cyc; trig = 1'b1; tick(); trig = 1'b0;
   endtask

   task automatic get_check_frame(input string nm);
      int k, bad;
      k = 0;
      while (rx_q.size() < NB && k < 3000) begin tick(); k++; end
      nchk++;
      got_q = rx_q;
      rx_q.delete();
      if (got_q.size() < NB) begin
         nerr++;
         $display("FAIL %s: got %0d bytes want %0d", nm, got_q.size(), NB);
      end else begin
         bad = -1;
         for (int i = NB - 1; i >= 0; i--) if (got_q[i] !== exp_q[i]) bad = i;
         if (bad >= 0) begin
            nerr++;
            $display("FAIL %s: byte %0d got %0h want %0h", nm, bad, got_q[bad], exp_q[bad]);
         end
      end
   endtask

   task automatic wait_idle(output int when);
      int k;
      k = 0;
      while (BUSY !== 1'b0 && k < 200) begin tick(); k++; end
      when = cyc;
      if (k >= 200) chk("busy_timeout", 32'(BUSY), 32'd0);
   endtask

   typedef struct {
      logic        sv;
      logic [3:0]  ra;
      logic [15:0] rd;
      logic [7:0]  pc;
      int          idx;
      logic [15:0] exp;
   } vec_t;
   vec_t vt [4];

   initial begin
      int c0, c2, b1, k;
      vt[0] = '{1'b1, 4'd3,  16'h1234, 8'h00, 18, 16'h1234};
      vt[1] = '{1'b0, 4'd5,  16'hFFFF, 8'h00, 22, 16'h0000};
      vt[2] = '{1'b1, 4'd15, 16'hA55A, 8'h07, 0,  16'hA507};
      vt[3] = '{1'b1, 4'd0,  16'h8001, 8'h07, 12, 16'h8001};
      foreach (m_sh[i]) m_sh[i] = '0;
      m_mflag = 1'b0; m_maddr = '0; m_mdata = '0;
      RST_N = 1'b0; SCAN_VALID = 1'b0; ra = '0; rd = '0; pc = '0; trig = 1'b0;
      memupd = 1'b0; memaddr = '0; memdata = '0;
      if_i = 16'h1001; id_i = 16'h2002; ex_i = 16'h3003; mem_i = 16'h4004; wb_i = 16'h5005;

      repeat (3) tick();
      chk("rst_tx", 32'(TX), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_ovr", 32'(OVERRUN), 32'd0);
      RST_N = 1'b1;
      repeat (5) tick();
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("idle_tx", 32'(TX), 32'd1);

      foreach (vt[v]) begin
         scan_write(vt[v].sv, vt[v].ra, vt[v].rd);
         tick();
         pc = vt[v].pc;
         rx_q.delete();
         pulse_trig(c0);
         build_exp();
         get_check_frame($sformatf("vec%0d_frame", v));
         chk($sformatf("vec%0d_bytes", v), {got_q[vt[v].idx], got_q[vt[v].idx + 1]}, vt[v].exp);
         chk($sformatf("vec%0d_latency", v), 32'(frame_fall - c0), 32'd3);
         wait_idle(b1);
         chk($sformatf("vec%0d_busylen", v), 32'(b1 - frame_fall), 32'(NB * 10 * CPB));
      end

      // Scan write in the LOAD cycle is in the frame; one in the START cycle is not.
      rx_q.delete();
      pulse_trig(c0);
      tick();
      SCAN_VALID = 1'b1; ra = 4'd9; rd = 16'h9A9A; m_sh[9] = 16'h9A9A;
      build_exp();
      tick();
      ra = 4'd10; rd = 16'hBBBB; m_sh[10] = 16'hBBBB;
      tick();
      SCAN_VALID = 1'b0;
      get_check_frame("wr_first_frame");
      chk("wr_first_r9", {got_q[30], got_q[31]}, 16'h9A9A);
      chk("wr_first_r10", {got_q[32], got_q[33]}, 16'h0000);
      wait_idle(b1);

      // Two PC changes mid-frame: coalesce into one follow-up frame, one OVERRUN pulse.
      rx_q.delete(); ovr_cnt = 0;
      pc = 8'h20;
      pulse_trig(c0);
      build_exp();
      repeat (300) tick();
      pc = 8'h21;
      tick();
      repeat (200) tick();
      c2 = cyc; pc = 8'h22;
      tick();
      get_check_frame("ovr_frame1");
      chk("ovr_frame1_pc", 32'(got_q[1]), 32'h20);
      chk("ovr_count", 32'(ovr_cnt), 32'd1);
      chk("ovr_when", 32'(ovr_cyc - c2), 32'd1);
      build_exp();
      wait_idle(b1);
      get_check_frame("ovr_frame2");
      chk("ovr_frame2_start", 32'(frame_fall - b1), 32'd2);
      wait_idle(b1);
      rx_q.delete();
      repeat (100) tick();
      chk("ovr_no_third", 32'(rx_q.size()) | 32'(rx_act), 32'd0);
      chk("ovr_count_end", 32'(ovr_cnt), 32'd1);

      for (int n = 0; n < 6; n++) begin
         k = $urandom_range(1, 6);
         for (int w = 0; w < k; w++)
            scan_write($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom));
         if_i = 16'($urandom); id_i = 16'($urandom); ex_i = 16'($urandom);
         mem_i = 16'($urandom); wb_i = 16'($urandom); pc = 8'($urandom);
         rx_q.delete();
         pulse_trig(c0);
         build_exp();
         get_check_frame($sformatf("rand%0d", n));
         wait_idle(b1);
      end

`ifdef CPU_TRACE_MEMUPD_EN
      memupd = 1'b1; memaddr = 8'h10; memdata = 16'hBEEF; tick();
      memaddr = 8'h11; memdata = 16'hCAFE; tick();
      memupd = 1'b0;
      m_mflag = 1'b1; m_maddr = 8'h11; m_mdata = 16'hCAFE;
      rx_q.delete();
      pulse_trig(c0);
      build_exp();
      get_check_frame("mem_frame1");
      chk("mem_tail1", {got_q[44], got_q[45], got_q[46], got_q[47]}, 32'h0111CAFE);
      wait_idle(b1);
      rx_q.delete();
      pulse_trig(c0);
      build_exp();
      get_check_frame("mem_frame2");
      chk("mem_tail2", {got_q[44], got_q[45], got_q[46], got_q[47]}, 32'h0);
      wait_idle(b1);
`endif

      // Reset while a 0 data bit of byte 0xA5 is on the line.
      rx_q.delete();
      pc = 8'h00;
      pulse_trig(c0);
      k = 0;
      while (!rx_act && k < 50) begin tick(); k++; end
      chk("rst_mid_started", 32'(rx_act), 32'd1);
      k = 0;
      while (cyc < frame_fall + 8 && k < 50) begin tick(); k++; end
      chk("rst_mid_pre_tx", 32'(TX), 32'd0);
      RST_N = 1'b0;
      tick();
      chk("rst_mid_tx", 32'(TX), 32'd1);
      chk("rst_mid_busy", 32'(BUSY), 32'd0);
      RST_N = 1'b1;
      foreach (m_sh[i]) m_sh[i] = '0;
      tick();
      rx_q.delete();
      repeat (200) tick();
      chk("rst_no_frame", 32'(rx_q.size()) | 32'(rx_act) | 32'(BUSY), 32'd0);

      chk("framing", 32'(rx_ferr), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
